// File: rtl/amp_detect.sv
// amp_detect: per-window amplitude estimator for two scope channels.
// Tracks max/min of wave_a/wave_b over 2^WIN_LOG2 strobes, converts each
// window into a symmetric peak code around mid-scale 128, and publishes the
// estimate once it has agreed with itself for STABLE_WIN consecutive windows.
// Pipeline: tracker -> snapshot -> estimate -> stability/output.

module amp_detect #(
  parameter int WIN_LOG2   = 12,
  parameter int STABLE_WIN = 2,
  parameter int TOL        = 2,
  parameter int MIN_SWING  = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sample_en,
  input  logic [7:0] wave_a,
  input  logic [7:0] wave_b,
  output logic [7:0] amplitude,
  output logic       amp_valid,
  output logic       amp_upd
);

  localparam logic [WIN_LOG2-1:0] CNT_ZERO  = {WIN_LOG2{1'b0}};
  localparam logic [WIN_LOG2-1:0] CNT_LAST  = {WIN_LOG2{1'b1}};
  localparam logic [WIN_LOG2-1:0] CNT_ONE   = {{(WIN_LOG2-1){1'b0}}, 1'b1};
  localparam logic [2:0]          STABLE_W3 = 3'(STABLE_WIN);
  localparam logic [8:0]          TOL_W9    = 9'(TOL);
  localparam logic [8:0]          SWING_W9  = 9'(MIN_SWING);

  // ---------------------------------------------------------------------------
  // Helper functions
  // ---------------------------------------------------------------------------

  // Symmetric peak code: (max + 256 - min) / 2, saturated to 8 bits.
  function automatic logic [7:0] est_of(input logic [7:0] mx, input logic [7:0] mn);
    logic [9:0] sum;
    logic [9:0] half;
    sum  = {2'b00, mx} + 10'd256 - {2'b00, mn};
    half = {1'b0, sum[9:1]};
    if (half > 10'd255) begin
      est_of = 8'd255;
    end else begin
      est_of = half[7:0];
    end
  endfunction

  // Peak-to-peak of one channel widened to 9 bits so it cannot wrap.
  function automatic logic [8:0] swing_of(input logic [7:0] mx, input logic [7:0] mn);
    swing_of = {1'b0, mx} - {1'b0, mn};
  endfunction

  // Smaller of two codes.
  function automatic logic [7:0] min8(input logic [7:0] x, input logic [7:0] y);
    if (x < y) begin
      min8 = x;
    end else begin
      min8 = y;
    end
  endfunction

  // Absolute difference of two codes.
  function automatic logic [7:0] abs_diff(input logic [7:0] x, input logic [7:0] y);
    if (x >= y) begin
      abs_diff = x - y;
    end else begin
      abs_diff = y - x;
    end
  endfunction

  // ---------------------------------------------------------------------------
  // Stage 0: window counter and running max/min trackers
  // ---------------------------------------------------------------------------
  logic [WIN_LOG2-1:0] cnt_q, cnt_d;
  logic [7:0]          max_a_q, max_a_d;
  logic [7:0]          min_a_q, min_a_d;
  logic [7:0]          max_b_q, max_b_d;
  logic [7:0]          min_b_q, min_b_d;
  logic                last_s;

  // Next tracker state: first strobe of a window seeds, later strobes extend.
  always_comb begin
    cnt_d   = cnt_q;
    max_a_d = max_a_q;
    min_a_d = min_a_q;
    max_b_d = max_b_q;
    min_b_d = min_b_q;
    last_s  = 1'b0;
    if (sample_en) begin
      cnt_d  = cnt_q + CNT_ONE;
      last_s = (cnt_q == CNT_LAST);
      if (cnt_q == CNT_ZERO) begin
        max_a_d = wave_a;
        min_a_d = wave_a;
        max_b_d = wave_b;
        min_b_d = wave_b;
      end else begin
        max_a_d = (wave_a > max_a_q) ? wave_a : max_a_q;
        min_a_d = (wave_a < min_a_q) ? wave_a : min_a_q;
        max_b_d = (wave_b > max_b_q) ? wave_b : max_b_q;
        min_b_d = (wave_b < min_b_q) ? wave_b : min_b_q;
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Tracker registers; gaps in sample_en simply hold them.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= CNT_ZERO;
      max_a_q <= 8'd0;
      min_a_q <= 8'd0;
      max_b_q <= 8'd0;
      min_b_q <= 8'd0;
    end else begin
      cnt_q   <= cnt_d;
      max_a_q <= max_a_d;
      min_a_q <= min_a_d;
      max_b_q <= max_b_d;
      min_b_q <= min_b_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1: snapshot of the completed window (includes the last sample)
  // ---------------------------------------------------------------------------
  logic [7:0] snap_max_a_q, snap_min_a_q;
  logic [7:0] snap_max_b_q, snap_min_b_q;
  logic       win_done_q;

  // Capture final extremes on the last strobe so the trackers can restart.
  always_ff @(posedge clk) begin
    if (rst) begin
      snap_max_a_q <= 8'd0;
      snap_min_a_q <= 8'd0;
      snap_max_b_q <= 8'd0;
      snap_min_b_q <= 8'd0;
      win_done_q   <= 1'b0;
    end else begin
      win_done_q <= last_s;
      if (last_s) begin
        snap_max_a_q <= max_a_d;
        snap_min_a_q <= min_a_d;
        snap_max_b_q <= max_b_d;
        snap_min_b_q <= min_b_d;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: per-channel estimate, candidate and swing qualification
  // ---------------------------------------------------------------------------
  logic [7:0] est_a_s, est_b_s;
  logic       swing_ok_s;
  logic [7:0] cand_q;
  logic       swing_ok_q;
  logic       est_vld_q;

  // Combinational estimate from the snapshot registers.
  always_comb begin
    est_a_s    = est_of(snap_max_a_q, snap_min_a_q);
    est_b_s    = est_of(snap_max_b_q, snap_min_b_q);
    swing_ok_s = (swing_of(snap_max_a_q, snap_min_a_q) >= SWING_W9) &&
                 (swing_of(snap_max_b_q, snap_min_b_q) >= SWING_W9);
  end

  // Register the candidate; the smaller channel estimate is the safe choice.
  always_ff @(posedge clk) begin
    if (rst) begin
      cand_q     <= 8'd0;
      swing_ok_q <= 1'b0;
      est_vld_q  <= 1'b0;
    end else begin
      est_vld_q <= win_done_q;
      if (win_done_q) begin
        cand_q     <= min8(est_a_s, est_b_s);
        swing_ok_q <= swing_ok_s;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 3: stability filter and published outputs
  // ---------------------------------------------------------------------------
  logic [7:0] prev_q, prev_d;
  logic       has_prev_q, has_prev_d;
  logic [2:0] agree_q, agree_d;
  logic [7:0] amp_q, amp_d;
  logic       valid_q, valid_d;
  logic       upd_q, upd_d;
  logic [8:0] diff_s;

  // Agreement bookkeeping; output is only written after enough agreements.
  always_comb begin
    prev_d     = prev_q;
    has_prev_d = has_prev_q;
    agree_d    = agree_q;
    amp_d      = amp_q;
    valid_d    = valid_q;
    upd_d      = 1'b0;
    diff_s     = {1'b0, abs_diff(cand_q, prev_q)};
    if (est_vld_q) begin
      if (!swing_ok_q) begin
        has_prev_d = 1'b0;
        agree_d    = 3'd0;
      end else if (!has_prev_q) begin
        prev_d     = cand_q;
        has_prev_d = 1'b1;
        agree_d    = 3'd0;
      end else if (diff_s <= TOL_W9) begin
        agree_d = (agree_q >= STABLE_W3) ? STABLE_W3 : (agree_q + 3'd1);
        prev_d  = cand_q;
        if (agree_d == STABLE_W3) begin
          amp_d   = cand_q;
          valid_d = 1'b1;
          upd_d   = 1'b1;
        end else begin
          upd_d = 1'b0;
        end
      end else begin
        prev_d  = cand_q;
        agree_d = 3'd0;
      end
    end else begin
      upd_d = 1'b0;
    end
  end

  // Stability state and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q     <= 8'd0;
      has_prev_q <= 1'b0;
      agree_q    <= 3'd0;
      amp_q      <= 8'd0;
      valid_q    <= 1'b0;
      upd_q      <= 1'b0;
    end else begin
      prev_q     <= prev_d;
      has_prev_q <= has_prev_d;
      agree_q    <= agree_d;
      amp_q      <= amp_d;
      valid_q    <= valid_d;
      upd_q      <= upd_d;
    end
  end

  assign amplitude = amp_q;
  assign amp_valid = valid_q;
  assign amp_upd   = upd_q;

endmodule

// File: tb/tb_amp_detect.sv
// Directed bench for amp_detect with a window-level reference model.
// Expected publishes (value and cycle) are queued when the last window
// strobe is driven and compared when amp_upd is observed.

module tb_amp_detect;

  localparam int WIN   = 16;
  localparam int SWIN  = 2;
  localparam int TOLP  = 2;
  localparam int MINSW = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       sample_en;
  logic [7:0] wave_a;
  logic [7:0] wave_b;
  logic [7:0] amplitude;
  logic       amp_valid;
  logic       amp_upd;

  amp_detect #(
    .WIN_LOG2  (4),
    .STABLE_WIN(SWIN),
    .TOL       (TOLP),
    .MIN_SWING (MINSW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .sample_en(sample_en),
    .wave_a   (wave_a),
    .wave_b   (wave_b),
    .amplitude(amplitude),
    .amp_valid(amp_valid),
    .amp_upd  (amp_upd)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int amp; int cyc; } pub_t;
  pub_t exp_q[$];

  int errors   = 0;
  int checks   = 0;
  int upd_seen = 0;
  logic prev_upd = 1'b0;

  // reference model state
  int m_cnt, m_max_a, m_min_a, m_max_b, m_min_b, m_prev, m_agree, m_amp;
  bit m_has_prev, m_valid;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic int tri_val(input int lo, input int hi, input int i);
    int k;
    k = (i <= 8) ? i : (16 - i);
    return lo + (hi - lo) * k / 8;
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_prev = 0; m_agree = 0; m_amp = 0;
    m_has_prev = 1'b0; m_valid = 1'b0;
    m_max_a = 0; m_min_a = 0; m_max_b = 0; m_min_b = 0;
    exp_q.delete();
  endtask

  task automatic window_end(input int pub_cyc);
    int ea, eb, cand, d;
    bit sw;
    ea = (m_max_a + 256 - m_min_a) / 2; if (ea > 255) ea = 255;
    eb = (m_max_b + 256 - m_min_b) / 2; if (eb > 255) eb = 255;
    cand = (ea < eb) ? ea : eb;
    sw = ((m_max_a - m_min_a) >= MINSW) && ((m_max_b - m_min_b) >= MINSW);
    if (!sw) begin
      m_has_prev = 1'b0; m_agree = 0;
    end else if (!m_has_prev) begin
      m_prev = cand; m_has_prev = 1'b1; m_agree = 0;
    end else begin
      d = cand - m_prev;
      if (d < 0) d = -d;
      if (d <= TOLP) begin
        m_agree = (m_agree + 1 > SWIN) ? SWIN : m_agree + 1;
        m_prev = cand;
        if (m_agree == SWIN) begin
          m_amp = cand; m_valid = 1'b1;
          exp_q.push_back('{amp: cand, cyc: pub_cyc});
        end
      end else begin
        m_prev = cand; m_agree = 0;
      end
    end
  endtask

  task automatic model_sample(input int a, input int b, input int pub_cyc);
    if (m_cnt == 0) begin
      m_max_a = a; m_min_a = a; m_max_b = b; m_min_b = b;
    end else begin
      if (a > m_max_a) m_max_a = a;
      if (a < m_min_a) m_min_a = a;
      if (b > m_max_b) m_max_b = b;
      if (b < m_min_b) m_min_b = b;
    end
    if (m_cnt == WIN - 1) window_end(pub_cyc);
    m_cnt = (m_cnt + 1) % WIN;
  endtask

  // one clock of stimulus; a strobe in this cycle publishes 3 edges later
  task automatic step(input logic en, input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    sample_en = en; wave_a = a; wave_b = b;
    if (en) model_sample(int'(a), int'(b), cyc + 3);
  endtask

  task automatic run(input int nsamp, input int la, input int ha,
                     input int lb, input int hb, input bit gap);
    for (int i = 0; i < nsamp; i++) begin
      step(1'b1, 8'(tri_val(la, ha, i % 16)), 8'(tri_val(lb, hb, i % 16)));
      if (gap) begin
        step(1'b0, 8'd0, 8'd0);
        step(1'b0, 8'd0, 8'd0);
      end
    end
  endtask

  task automatic do_rst(input logic en);
    @(negedge clk);
    rst = 1'b1; sample_en = en;
    @(negedge clk);
    rst = 1'b0; sample_en = 1'b0;
    model_reset();
  endtask

  task automatic settle(input string tag);
    repeat (6) step(1'b0, 8'd0, 8'd0);
    chk({tag, "_pending"}, exp_q.size(), 32'd0);
    chk({tag, "_amp"}, {24'd0, amplitude}, m_amp);
    chk({tag, "_valid"}, {31'd0, amp_valid}, {31'd0, m_valid});
  endtask

  // publish monitor: every amp_upd must match the oldest queued expectation
  initial begin
    pub_t p;
    forever begin
      @(negedge clk);
      if (amp_upd === 1'b1) begin
        upd_seen++;
        chk("upd_width", {31'd0, prev_upd}, 32'd0);
        chk("upd_valid", {31'd0, amp_valid}, 32'd1);
        chk("upd_pending", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          p = exp_q.pop_front();
          chk("upd_amp", {24'd0, amplitude}, p.amp);
          chk("upd_cycle", cyc, p.cyc);
        end
      end
      prev_upd = amp_upd;
    end
  end

  initial begin
    rst = 1'b1; sample_en = 1'b0; wave_a = 8'd128; wave_b = 8'd128;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_amp", {24'd0, amplitude}, 32'd0);
    chk("reset_valid", {31'd0, amp_valid}, 32'd0);
    chk("reset_upd", {31'd0, amp_upd}, 32'd0);

    // symmetric triangle 28..228 on both channels
    run(3 * WIN, 28, 228, 28, 228, 1'b0);
    settle("sym");
    chk("sym_amp228", {24'd0, amplitude}, 32'd228);
    chk("sym_nupd", upd_seen, 32'd1);
    run(WIN, 28, 228, 28, 228, 1'b0);
    settle("sym_more");
    chk("sym_more_nupd", upd_seen, 32'd2);

    // step change to 58..198: one disagreeing window, then two agreeing
    run(WIN, 58, 198, 58, 198, 1'b0);
    settle("step_hold");
    chk("step_hold_amp228", {24'd0, amplitude}, 32'd228);
    run(2 * WIN, 58, 198, 58, 198, 1'b0);
    settle("step_new");
    chk("step_new_amp198", {24'd0, amplitude}, 32'd198);
    chk("step_valid", {31'd0, amp_valid}, 32'd1);
    chk("step_nupd", upd_seen, 32'd3);

    // unequal channels: B's estimate wins
    run(3 * WIN, 28, 228, 78, 178, 1'b0);
    settle("uneq");
    chk("uneq_amp178", {24'd0, amplitude}, 32'd178);

    // flat A never qualifies; then triangle on A publishes
    do_rst(1'b0);
    run(4 * WIN, 128, 128, 28, 228, 1'b0);
    settle("flat");
    chk("flat_valid", {31'd0, amp_valid}, 32'd0);
    chk("flat_nupd", upd_seen, 32'd4);
    run(3 * WIN, 28, 228, 28, 228, 1'b0);
    settle("flat_tri");
    chk("flat_tri_amp228", {24'd0, amplitude}, 32'd228);

    // jitter 230/228 within TOL: publish every window
    for (int k = 0; k < 2; k++) begin
      run(WIN, 26, 230, 26, 230, 1'b0);
      run(WIN, 28, 228, 28, 228, 1'b0);
    end
    settle("jit_ok");
    chk("jit_ok_nupd", upd_seen, 32'd9);

    // jitter 232/228 beyond TOL: no publishes
    for (int k = 0; k < 2; k++) begin
      run(WIN, 24, 232, 24, 232, 1'b0);
      run(WIN, 28, 228, 28, 228, 1'b0);
    end
    settle("jit_big");
    chk("jit_big_nupd", upd_seen, 32'd9);
    chk("jit_big_amp228", {24'd0, amplitude}, 32'd228);

    // reset at sample 9 of window 2, then a fresh run
    run(WIN + 9, 28, 228, 28, 228, 1'b0);
    do_rst(1'b1);
    chk("rst_amp", {24'd0, amplitude}, 32'd0);
    chk("rst_valid", {31'd0, amp_valid}, 32'd0);
    chk("rst_upd", {31'd0, amp_upd}, 32'd0);
    run(3 * WIN, 28, 228, 28, 228, 1'b0);
    settle("rst_run");
    chk("rst_run_amp228", {24'd0, amplitude}, 32'd228);
    chk("rst_run_nupd", upd_seen, 32'd10);

    // same with sample_en 1-of-3
    run(WIN + 9, 28, 228, 28, 228, 1'b1);
    do_rst(1'b1);
    chk("gap_rst_amp", {24'd0, amplitude}, 32'd0);
    chk("gap_rst_valid", {31'd0, amp_valid}, 32'd0);
    run(3 * WIN, 28, 228, 28, 228, 1'b1);
    settle("gap_run");
    chk("gap_run_amp228", {24'd0, amplitude}, 32'd228);
    chk("gap_run_nupd", upd_seen, 32'd12);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
